// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the five-stage pipeline: boot flush, memory freeze, branch redirect, load-use bubble.
// Optional build macro PIPE_PERF_EN adds the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int BOOT_CYC    = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        use_rs1_D,
  input  logic        use_rs2_D,
  input  logic [4:0]  rd_E,
  input  logic        WEN_E,
  input  logic        MemToReg_E,
  input  logic        br_taken_E,
  input  logic        DREQ_M,
  input  logic        DRDY_M,
  output logic        en_PC,
  output logic        en_FD,
  output logic        en_DE,
  output logic        en_EM,
  output logic        en_MW,
  output logic        flush_FD,
  output logic        flush_DE,
  output logic        pc_sel,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

  typedef enum logic [1:0] {BOOT, RUN, MWAIT} state_t;

  state_t          state_q;
  logic [BW-1:0]   boot_cnt_q;
  logic [15:0]     wait_cnt_q;
  logic            mem_err_q;

  logic in_boot;
  logic freeze;
  logic raw_hz;
  logic branch;
  logic load_use;

  // RST gates the outputs too, so the boot pattern is visible in the reset cycle itself.
  assign in_boot  = RST || (state_q == BOOT);
  assign freeze   = !in_boot && !DRDY_M && (DREQ_M || (state_q == MWAIT));
  assign raw_hz   = MemToReg_E && WEN_E && (rd_E != 5'd0) &&
                    ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));
  assign branch   = !in_boot && !freeze && br_taken_E;
  assign load_use = !in_boot && !freeze && !br_taken_E && raw_hz;

  always_comb begin
    en_PC    = 1'b1;
    en_FD    = 1'b1;
    en_DE    = 1'b1;
    en_EM    = 1'b1;
    en_MW    = 1'b1;
    flush_FD = 1'b0;
    flush_DE = 1'b0;
    pc_sel   = 1'b0;
    if (in_boot) begin
      en_PC    = 1'b0;
      flush_FD = 1'b1;
      flush_DE = 1'b1;
    end else if (freeze) begin
      en_PC = 1'b0;
      en_FD = 1'b0;
      en_DE = 1'b0;
      en_EM = 1'b0;
      en_MW = 1'b0;
    end else if (branch) begin
      pc_sel   = 1'b1;
      flush_FD = 1'b1;
      flush_DE = 1'b1;
    end else if (load_use) begin
      // D/E still loads, but a bubble; the load advances to M and the hazard clears next cycle.
      en_PC    = 1'b0;
      en_FD    = 1'b0;
      flush_DE = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          if (boot_cnt_q == BW'(BOOT_CYC - 1)) begin
            state_q    <= RUN;
            boot_cnt_q <= '0;
          end else begin
            boot_cnt_q <= boot_cnt_q + 1'b1;
          end
        end
        RUN:     if (freeze) state_q <= MWAIT;
        MWAIT:   if (!freeze) state_q <= RUN;
        default: state_q <= BOOT;
      endcase

      if (freeze) begin
        if (wait_cnt_q < 16'(MEM_TIMEOUT)) wait_cnt_q <= wait_cnt_q + 16'd1;
        if (wait_cnt_q >= 16'(MEM_TIMEOUT - 1)) mem_err_q <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze || load_use) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch)             flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
